// File: rtl/sram_arbiter.sv
// Two-master controller for an external asynchronous SRAM: video (priority, read-only) and CPU.
// Each access is timed by a down-counter so the SRAM access and write-pulse times are met.
module sram_arbiter #(
    parameter int AW        = 19,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic          clk,
    input  logic          power_on_reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_dout,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] sram_addr,
    inout  wire  [7:0]    sram_data,
    output logic          sram_we_n
);
    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              grant_vid_reg;
    logic              fair_reg;
    logic [7:0]        wdata_reg;

    logic vid_valid;
    logic cpu_valid;
    logic pick_vid;
    logic pick_cpu;

    // A port whose ack is high is ignored this edge; fair_reg blocks a second
    // consecutive video grant while the CPU has been kept waiting.
    always_comb begin
        vid_valid = vid_req && !vid_ack;
        cpu_valid = cpu_req && !cpu_ack;
        pick_vid  = vid_valid && !(cpu_valid && fair_reg);
        pick_cpu  = cpu_valid && !pick_vid;
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            grant_vid_reg <= 1'b0;
            fair_reg      <= 1'b0;
            wdata_reg     <= '0;
            sram_addr     <= '0;
            sram_we_n     <= 1'b1;
            vid_dout      <= '0;
            cpu_dout      <= '0;
            vid_ack       <= 1'b0;
            cpu_ack       <= 1'b0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_vid) begin
                        sram_addr     <= vid_addr;
                        cnt_reg       <= CNT_W'(RD_CYCLES - 1);
                        grant_vid_reg <= 1'b1;
                        fair_reg      <= cpu_valid;
                        state_reg     <= READ;
                    end else if (pick_cpu) begin
                        sram_addr     <= cpu_addr;
                        grant_vid_reg <= 1'b0;
                        fair_reg      <= 1'b0;
                        if (cpu_we) begin
                            wdata_reg <= cpu_din;
                            sram_we_n <= 1'b0;
                            cnt_reg   <= CNT_W'(WR_CYCLES - 1);
                            state_reg <= WRITE;
                        end else begin
                            cnt_reg   <= CNT_W'(RD_CYCLES - 1);
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt_reg == '0) begin
                        if (grant_vid_reg) begin
                            vid_dout <= sram_data;
                            vid_ack  <= 1'b1;
                        end else begin
                            cpu_dout <= sram_data;
                            cpu_ack  <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                WRITE: begin
                    // Address is deliberately left alone here so it outlives the we_n rise.
                    if (cnt_reg == '0) begin
                        sram_we_n <= 1'b1;
                        cpu_ack   <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Bus is driven only while the write strobe is low, so it can never fight SRAM read data.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bus
            assign sram_data[gi] = sram_we_n ? 1'bz : wdata_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: an SRAM model on the pins, a vector table, hand sequences for
// contention / back-to-back / reset-abort, and a randomized two-master run against a memory model.
module tb_sram_arbiter;
    localparam int AW = 19;
    localparam logic [1:0] OP_CW = 2'd0;
    localparam logic [1:0] OP_CR = 2'd1;
    localparam logic [1:0] OP_VR = 2'd2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [7:0]    vid_dout;
    logic          vid_ack;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic [AW-1:0] sram_addr;
    tri1  [7:0]    sram_data;
    logic          sram_we_n;

    int n_cmp = 0;
    int n_bad = 0;
    logic model_oe = 1'b0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(AW), .RD_CYCLES(2), .WR_CYCLES(2)) dut (
        .clk(clk), .power_on_reset_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n)
    );

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    // Asynchronous SRAM: outputs whenever not being written, latches data while we_n is low.
    logic [7:0] mem [0:(1<<AW)-1];
    assign sram_data = (model_oe && sram_we_n) ? mem[sram_addr] : 8'bz;
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
        forever begin
            @(negedge clk);
            if (sram_we_n == 1'b0) mem[sram_addr] = sram_data;
        end
    end

    // Reference memory: what every completed CPU write has stored.
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: pulse width, address hold at the rise, bus data while driven.
    initial begin : mon
        int low_run;
        logic [AW-1:0] low_addr;
        low_run = 0;
        low_addr = '0;
        forever begin
            @(negedge clk);
            check("acks_exclusive", 32'(vid_ack & cpu_ack), 32'd0);
            if (!mon_en) begin
                low_run = 0;
            end else if (!sram_we_n) begin
                low_run++;
                low_addr = sram_addr;
                check("wr_bus_data", 32'(sram_data), 32'(cpu_din));
            end else if (low_run != 0) begin
                check("we_n_low_cycles", low_run, 32'd2);
                check("addr_hold_at_we_rise", 32'(sram_addr), 32'(low_addr));
                low_run = 0;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge on which ack was seen.
    task automatic do_access(input logic is_vid, input logic we, input logic [AW-1:0] addr,
                             input logic [7:0] din, output logic [7:0] dout, output int cycles);
        cycles = 0;
        if (is_vid) begin
            vid_addr = addr; vid_req = 1'b1;
        end else begin
            cpu_addr = addr; cpu_we = we; cpu_din = din; cpu_req = 1'b1;
        end
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!(is_vid ? vid_ack : cpu_ack) && cycles < 20);
        if (is_vid) begin
            vid_req = 1'b0; dout = vid_dout;
        end else begin
            cpu_req = 1'b0; dout = cpu_dout;
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [7:0]    exp;
    } vec_t;

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[8];
        logic [7:0] d;
        int cyc;
        int order[$];

        vecs[0] = '{OP_CW, 19'h12345, 8'h5A, 8'h00};
        vecs[1] = '{OP_CR, 19'h12345, 8'h00, 8'h5A};
        vecs[2] = '{OP_CW, 19'h7FFFF, 8'hA5, 8'h00};
        vecs[3] = '{OP_CW, 19'h00000, 8'h3C, 8'h00};
        vecs[4] = '{OP_VR, 19'h7FFFF, 8'h00, 8'hA5};
        vecs[5] = '{OP_VR, 19'h00000, 8'h00, 8'h3C};
        vecs[6] = '{OP_CR, 19'h7FFFF, 8'h00, 8'hA5};
        vecs[7] = '{OP_VR, 19'h12345, 8'h00, 8'h5A};

        // Reset held with random inputs, bus observed with the SRAM model silent.
        #3 rst_n = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            vid_req = 1'($urandom); cpu_req = 1'($urandom); cpu_we = 1'($urandom);
            vid_addr = AW'($urandom); cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
            @(negedge clk);
            check("rst_we_n", 32'(sram_we_n), 32'd1);
            check("rst_bus_z", 32'(sram_data), 32'hFF);
            check("rst_acks", 32'({vid_ack, cpu_ack}), 32'd0);
            check("rst_addr", 32'(sram_addr), 32'd0);
            check("rst_douts", 32'({vid_dout, cpu_dout}), 32'd0);
        end
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            check("idle_addr", 32'(sram_addr), 32'd0);
            check("idle_bus_z", 32'(sram_data), 32'hFF);
        end
        model_oe = 1'b1;
        mon_en = 1'b1;

        // Vector table: single accesses, each on an otherwise idle arbiter.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            do_access(vecs[i].op == OP_VR, vecs[i].op == OP_CW, vecs[i].addr, vecs[i].data, d, cyc);
            check($sformatf("vec%0d_latency", i), cyc, 32'd3);
            if (vecs[i].op != OP_CW) check($sformatf("vec%0d_dout", i), 32'(d), 32'(vecs[i].exp));
            if (vecs[i].op == OP_CW) ref_mem[int'(vecs[i].addr)] = vecs[i].data;
            @(posedge clk); #1;
            check($sformatf("vec%0d_ack_pulse", i), 32'({vid_ack, cpu_ack}), 32'd0);
            $display("vec %0d op=%0d addr=%05h data=%02h dout=%02h cycles=%0d",
                     i, vecs[i].op, vecs[i].addr, vecs[i].data, d, cyc);
        end

        // Both requests rise together and stay up: grants must go V, C, V, C, V, C.
        @(posedge clk); #1;
        vid_addr = 19'h00000; cpu_addr = 19'h7FFFF; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            @(posedge clk); #1;
            if (vid_ack) order.push_back(0);
            if (cpu_ack) order.push_back(1);
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check("contention_grants", order.size(), 32'd6);
        for (int k = 0; k < order.size(); k++) check($sformatf("contention_order%0d", k), order[k], k % 2);
        check("contention_vid_dout", 32'(vid_dout), 32'h3C);
        check("contention_cpu_dout", 32'(cpu_dout), 32'hA5);
        $display("contention: %0d grants observed", order.size());

        // Back-to-back writes, second request raised in the first ack cycle.
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 19'h00100, 8'h11, d, cyc);
        check("b2b_wr1_latency", cyc, 32'd3);
        do_access(1'b0, 1'b1, 19'h00101, 8'h22, d, cyc);
        check("b2b_wr2_latency", cyc, 32'd4);
        ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22;
        do_access(1'b0, 1'b0, 19'h00100, 8'h00, d, cyc);
        check("b2b_rd1", 32'(d), 32'h11);
        do_access(1'b1, 1'b0, 19'h00101, 8'h00, d, cyc);
        check("b2b_rd2", 32'(d), 32'h22);
        $display("back-to-back writes done");

        // Reset one cycle into a write: strobe and bus released with no clock edge, no ack.
        @(posedge clk); #1;
        mon_en = 1'b0;
        cpu_addr = 19'h55555; cpu_we = 1'b1; cpu_din = 8'h77; cpu_req = 1'b1;
        @(posedge clk); #1;
        check("mw_we_low", 32'(sram_we_n), 32'd0);
        @(posedge clk); #1;
        model_oe = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mw_we_async", 32'(sram_we_n), 32'd1);
        check("mw_bus_release", 32'(sram_data), 32'hFF);
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("mw_no_ack", 32'(cpu_ack), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_oe = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mw_post_ack", 32'(cpu_ack), 32'd0);
            check("mw_post_addr", 32'(sram_addr), 32'd0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_access(1'b0, 1'b0, 19'h12345, 8'h00, d, cyc);
        check("mw_idle_latency", cyc, 32'd3);
        check("mw_idle_rd", 32'(d), 32'h5A);
        $display("reset mid-write done");

        // Randomized: two independent masters, checked against the reference memory.
        fork
            begin : cpu_m
                logic [7:0] rd;
                int cc;
                logic [AW-1:0] a;
                logic [7:0] wd;
                logic w;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(2)) begin @(posedge clk); #1; end
                    a = 19'h40000 + AW'($urandom_range(15));
                    w = 1'($urandom);
                    wd = 8'($urandom);
                    do_access(1'b0, w, a, wd, rd, cc);
                    check("rand_cpu_latency", 32'(cc >= 3 && cc <= 7), 32'd1);
                    if (w) ref_mem[int'(a)] = wd;
                    else check("rand_cpu_rd", 32'(rd), 32'(ref_read(a)));
                    $display("rand cpu %0d we=%0d addr=%05h data=%02h cycles=%0d", k, w, a, w ? wd : rd, cc);
                end
            end
            begin : vid_m
                logic [7:0] rd;
                int cc;
                logic [AW-1:0] a;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(2)) begin @(posedge clk); #1; end
                    a = 19'h40000 + AW'($urandom_range(15));
                    do_access(1'b1, 1'b0, a, 8'h00, rd, cc);
                    check("rand_vid_latency", 32'(cc >= 3 && cc <= 7), 32'd1);
                    check("rand_vid_rd", 32'(rd), 32'(ref_read(a)));
                    $display("rand vid %0d addr=%05h data=%02h cycles=%0d", k, a, rd, cc);
                end
            end
        join

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
